// File: rtl/i2c_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder_if
// Description : I2C pins, received-byte pulse and memory preload port of the
//               I2C target responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_responder_if #(
    parameter int PW = 4,
    parameter int DW = 8
);
    logic          scl_i;
    logic          sda_i;
    logic          sda_o;
    logic          busy_o;
    logic          wr_valid_o;
    logic [PW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          load_en_i;
    logic [PW-1:0] load_addr_i;
    logic [DW-1:0] load_data_i;

    modport slave (
        input  scl_i, sda_i, load_en_i, load_addr_i, load_data_i,
        output sda_o, busy_o, wr_valid_o, wr_addr_o, wr_data_o
    );

    modport master (
        output scl_i, sda_i, load_en_i, load_addr_i, load_data_i,
        input  sda_o, busy_o, wr_valid_o, wr_addr_o, wr_data_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder
// Description : I2C target with fixed address, auto-incrementing pointer and
//               a small byte memory serving writes and reads.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_responder #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        MEM_DEPTH      = 16
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    i2c_slave_responder_if.slave bus
);
    localparam int DW = I2C_DATA_WIDTH;
    localparam int PW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(I2C_DATA_WIDTH);
    localparam logic [CW-1:0] c_LAST_BIT = CW'(I2C_DATA_WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_INC  = 1;
    localparam logic [PW-1:0] c_PTR_INC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_PTR      = 3'd3,
        ST_WR_BYTE  = 3'd4,
        ST_WR_ACK   = 3'd5,
        ST_RD_BYTE  = 3'd6,
        ST_RD_MACK  = 3'd7
    } state_t;

    logic r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [DW-1:0] r_shift, w_shift_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic          r_sda_o, w_sda_o_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_mack, w_mack_nxt;
    logic          r_wr_valid, w_wr_valid_nxt;
    logic [PW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DW-1:0] r_wr_data, w_wr_data_nxt;
    logic          w_mem_we;
    logic [DW-1:0] w_byte;
    logic [DW-1:0] w_mem_rd;
    logic [DW-1:0] r_mem [MEM_DEPTH];

    // Idle bus is high, so sync flops reset high to avoid a spurious START/STOP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_s1   <= bus.scl_i;
            r_scl_s2   <= r_scl_s1;
            r_scl_d    <= r_scl_s2;
            r_sda_s1   <= bus.sda_i;
            r_sda_s2   <= r_sda_s1;
            r_sda_d    <= r_sda_s2;
            r_scl_rise <= r_scl_s2 & ~r_scl_d;
            r_scl_fall <= ~r_scl_s2 & r_scl_d;
            r_start    <= ~r_sda_s2 & r_sda_d & r_scl_s2 & r_scl_d;
            r_stop     <= r_sda_s2 & ~r_sda_d & r_scl_s2 & r_scl_d;
        end
    end

    // r_sda_d is aligned with the registered edge pulses.
    assign w_byte   = {r_shift[DW-2:0], r_sda_d};
    assign w_mem_rd = r_mem[r_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_sda_o    <= 1'b1;
            r_rw       <= 1'b0;
            r_mack     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sda_o    <= w_sda_o_nxt;
            r_rw       <= w_rw_nxt;
            r_mack     <= w_mack_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_ptr_nxt      = r_ptr;
        w_sda_o_nxt    = r_sda_o;
        w_rw_nxt       = r_rw;
        w_mack_nxt     = r_mack;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_mem_we       = 1'b0;
        if (r_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_o_nxt   = 1'b1;
        end else if (r_stop) begin
            w_state_nxt = ST_IDLE;
            w_sda_o_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR: if (r_scl_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_INC;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_rw_nxt      = w_byte[0];
                        w_state_nxt   = (w_byte[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR)
                                        ? ST_ADDR_ACK : ST_IDLE;
                    end
                end
                // Released SDA marks the first fall (start ACK); low marks the closing one.
                ST_ADDR_ACK: if (r_scl_fall) begin
                    if (r_sda_o) begin
                        w_sda_o_nxt = 1'b0;
                    end else if (r_rw) begin
                        w_state_nxt   = ST_RD_BYTE;
                        w_shift_nxt   = w_mem_rd;
                        w_sda_o_nxt   = w_mem_rd[DW-1];
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_PTR;
                        w_sda_o_nxt = 1'b1;
                    end
                end
                ST_PTR: if (r_scl_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_INC;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_ptr_nxt     = w_byte[PW-1:0];
                        w_state_nxt   = ST_WR_ACK;
                    end
                end
                ST_WR_BYTE: if (r_scl_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_INC;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt  = '0;
                        w_wr_valid_nxt = 1'b1;
                        w_wr_addr_nxt  = r_ptr;
                        w_wr_data_nxt  = w_byte;
                        w_mem_we       = 1'b1;
                        w_ptr_nxt      = r_ptr + c_PTR_INC;
                        w_state_nxt    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (r_scl_fall) begin
                    if (r_sda_o) begin
                        w_sda_o_nxt = 1'b0;
                    end else begin
                        w_sda_o_nxt = 1'b1;
                        w_state_nxt = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: if (r_scl_fall) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_sda_o_nxt   = 1'b1;
                        w_ptr_nxt     = r_ptr + c_PTR_INC;
                        w_mack_nxt    = 1'b0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_RD_MACK;
                    end else begin
                        w_sda_o_nxt   = r_shift[DW-2];
                        w_shift_nxt   = {r_shift[DW-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_INC;
                    end
                end
                ST_RD_MACK: begin
                    if (r_scl_rise) begin
                        if (!r_sda_d) begin
                            w_mack_nxt  = 1'b1;
                            w_shift_nxt = w_mem_rd;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_scl_fall && r_mack) begin
                        w_state_nxt   = ST_RD_BYTE;
                        w_sda_o_nxt   = r_shift[DW-1];
                        w_bit_cnt_nxt = '0;
                        w_mack_nxt    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load first so an I2C write to the same address in the same cycle wins.
    always_ff @(posedge clk_i) begin
        if (bus.load_en_i) begin
            r_mem[bus.load_addr_i] <= bus.load_data_i;
        end
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    assign bus.sda_o      = r_sda_o;
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.wr_valid_o = r_wr_valid;
    assign bus.wr_addr_o  = r_wr_addr;
    assign bus.wr_data_o  = r_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_responder
// Description : Bit-banged I2C master with write scoreboard for the responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;
    localparam int Q = 100;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   low_seen = 0;
    logic watch_en = 1'b0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] v;
    logic s_dummy;

    always #5 clk = ~clk;

    i2c_slave_responder_if #(.PW(4), .DW(8)) ifc();

    assign ifc.scl_i = scl_m;
    assign ifc.sda_i = sda_m & ifc.sda_o;

    i2c_slave_responder #(
        .I2C_ADDR_WIDTH(7),
        .I2C_DATA_WIDTH(8),
        .SLAVE_ADDR(7'h22),
        .MEM_DEPTH(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (ifc.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every wr_valid pulse must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && ifc.wr_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got addr=%0d data=0x%0h expected no write",
                         ifc.wr_addr_o, ifc.wr_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(ifc.wr_addr_o), 32'(mon_e.a));
                check("wr_data", 32'(ifc.wr_data_o), 32'(mon_e.d));
            end
        end
        if (watch_en && ifc.sda_o !== 1'b1) low_seen++;
    end

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        #Q scl_m = 1'b1;
        #Q s = ifc.sda_i;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop(input string tag);
        int n;
        n = 0;
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (ifc.busy_o === 1'b0) break;
        end
        checks++;
        if (ifc.busy_o !== 1'b0 || n > 4) begin
            failures++;
            $display("FAIL %s_busy_fall: got busy=%b after %0d clk expected busy=0 within 4 clk",
                     tag, ifc.busy_o, n);
        end
        @(negedge clk);
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        if (!exp_ack) check({tag, "_busy_after_8"}, 32'(ifc.busy_o), 32'd0);
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q check({tag, "_ack_early"}, 32'(ifc.sda_o), exp_ack ? 32'd0 : 32'd1);
        #(Q - 10) check({tag, "_ack_late"}, 32'(ifc.sda_o), exp_ack ? 32'd0 : 32'd1);
        #10 scl_m = 1'b0;
        #Q;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] val);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            val[i] = s;
        end
        bit_cycle(~ack, s);
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ifc.load_en_i   = 1'b1;
        ifc.load_addr_i = a;
        ifc.load_data_i = d;
        @(negedge clk);
        ifc.load_en_i   = 1'b0;
    endtask

    initial begin
        ifc.load_en_i   = 1'b0;
        ifc.load_addr_i = '0;
        ifc.load_data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_sda_o", 32'(ifc.sda_o), 32'd1);
        check("rst_busy", 32'(ifc.busy_o), 32'd0);
        check("rst_wr_valid", 32'(ifc.wr_valid_o), 32'd0);
        check("rst_wr_addr", 32'(ifc.wr_addr_o), 32'd0);
        check("rst_wr_data", 32'(ifc.wr_data_o), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write: pointer 3, then two data bytes
        exp_q.push_back('{4'd3, 8'hA5});
        exp_q.push_back('{4'd4, 8'h5A});
        i2c_start();
        write_byte(8'h44, 1'b1, "w_addr");
        write_byte(8'h03, 1'b1, "w_ptr");
        write_byte(8'hA5, 1'b1, "w_d0");
        write_byte(8'h5A, 1'b1, "w_d1");
        i2c_stop("w");

        // Read with repeated START
        preload(4'd7, 8'hC3);
        preload(4'd8, 8'h3C);
        i2c_start();
        write_byte(8'h44, 1'b1, "r_waddr");
        write_byte(8'h07, 1'b1, "r_ptr");
        i2c_start();
        write_byte(8'h45, 1'b1, "r_raddr");
        read_byte(1'b1, v);
        check("rd_byte0", 32'(v), 32'h0C3);
        read_byte(1'b0, v);
        check("rd_byte1", 32'(v), 32'h03C);
        check("rd_release_after_nack", 32'(ifc.sda_o), 32'd1);
        check("rd_idle_after_nack", 32'(ifc.busy_o), 32'd0);
        i2c_stop("r");

        // Address mismatch
        low_seen = 0;
        watch_en = 1'b1;
        i2c_start();
        write_byte(8'h46, 1'b0, "mm_addr");
        write_byte(8'h11, 1'b0, "mm_data");
        i2c_stop("mm");
        watch_en = 1'b0;
        check("mm_sda_low_samples", 32'(low_seen), 32'd0);

        // Pointer wrap
        exp_q.push_back('{4'd15, 8'h01});
        exp_q.push_back('{4'd0, 8'h02});
        i2c_start();
        write_byte(8'h44, 1'b1, "wr_addr");
        write_byte(8'h0F, 1'b1, "wr_ptr");
        write_byte(8'h01, 1'b1, "wr_d0");
        write_byte(8'h02, 1'b1, "wr_d1");
        i2c_stop("wrap");

        // Abort after four data bits, then a full write
        i2c_start();
        write_byte(8'h44, 1'b1, "ab_addr");
        write_byte(8'h05, 1'b1, "ab_ptr");
        bit_cycle(1'b1, s_dummy);
        bit_cycle(1'b0, s_dummy);
        bit_cycle(1'b1, s_dummy);
        bit_cycle(1'b1, s_dummy);
        i2c_stop("ab");
        check("ab_idle", 32'(ifc.busy_o), 32'd0);
        exp_q.push_back('{4'd5, 8'h77});
        i2c_start();
        write_byte(8'h44, 1'b1, "ab2_addr");
        write_byte(8'h05, 1'b1, "ab2_ptr");
        write_byte(8'h77, 1'b1, "ab2_d0");
        i2c_stop("ab2");

        // Reset while the responder holds SDA low
        preload(4'd0, 8'h96);
        preload(4'd10, 8'h00);
        i2c_start();
        write_byte(8'h44, 1'b1, "rs_waddr");
        write_byte(8'h0A, 1'b1, "rs_ptr");
        i2c_start();
        write_byte(8'h45, 1'b1, "rs_raddr");
        check("rs_pre_sda_low", 32'(ifc.sda_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rs_sda_released", 32'(ifc.sda_o), 32'd1);
        check("rs_busy", 32'(ifc.busy_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        i2c_start();
        write_byte(8'h45, 1'b1, "rs2_raddr");
        read_byte(1'b0, v);
        check("rs_ptr_zero_read", 32'(v), 32'h096);
        i2c_stop("rs2");

        repeat (10) @(negedge clk);
        check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
